exec_alu_mdu: RTL and testbench
===============================

Name: exec_alu_mdu

Overview:
Next-generation execute-stage ALU for the MIPS pipeline. It merges ALU control decode (aluop/funct to operation) with a WIDTH-parametrised datapath and an iterative multiply/divide unit (MDU) that owns the HI/LO registers. Single-cycle ops produce a combinational result in EX. mult/multu/div/divu run in the background for WIDTH cycles. A dependent mfhi/mflo, or a second MDU op, raises stall until the MDU finishes.

Parameters:
- WIDTH, 32: datapath width; also the MDU iteration count.
- CNT_W, $clog2(WIDTH+1): width of the MDU iteration counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: a valid instruction occupies EX this cycle.
- aluop, input, 2: main-decoder class. 00 = add (lw/sw), 01 = sub (beq), 10 = R-type (use funct), 11 = or (ori).
- funct, input, 6: R-type function field.
- a, input, WIDTH: rs operand.
- b, input, WIDTH: rt operand or immediate.
- shamt, input, 5: shift amount.
- result, output, WIDTH: EX result; combinational.
- zero, output, 1: result == 0.
- stall, output, 1: hold IF/ID/EX, bubble into MEM.
- mdu_busy, output, 1: an MDU operation is in flight.
- illegal, output, 1: in_valid with an unsupported funct.

Behaviour:
- Decode: funct 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu, 000000 sll, 000010 srl, 000011 sra, 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo.
- Any other funct with aluop=10: result=0, illegal=1, no state change. illegal is 0 when in_valid=0.
- add/sub wrap modulo 2^WIDTH; no overflow trap.
- slt/sltu result is zero-extended 0/1.
- Shifts use b as the source and shamt[$clog2(WIDTH)-1:0].
- mfhi/mflo: result = HI/LO.
- MDU ops: result=0.
- MDU FSM states: IDLE, RUN, DONE.
- IDLE: if in_valid and an MDU op and not stall, latch operands, sign flags and op type. Go to RUN with cnt=0.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle, cnt++. After WIDTH steps go to DONE.
- DONE: apply sign correction, write HI/LO, go to IDLE. DONE lasts exactly one cycle.
- Timing: MDU op accepted in cycle t. mdu_busy is high in cycles t+1 through t+WIDTH+1. HI/LO update on the edge ending cycle t+WIDTH+1. mdu_busy is low in cycle t+WIDTH+2.
- mfhi/mflo in cycle t+WIDTH+2 reads the new value. There is no bypass from the DONE cycle.
- stall = in_valid & mdu_busy & (op is mfhi, mflo or any MDU op). All other ops proceed while the MDU runs.
- The accepting instruction itself never stalls.
- Signed mult: HI:LO = signed product, 2*WIDTH bits.
- Signed div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero (div and divu): LO = all ones, HI = a. This takes the same latency; no trap.
- Most-negative / -1 (signed div): LO = most-negative, HI = 0.
- Reset: FSM=IDLE, cnt=0, HI=LO=0, mdu_busy=0, stall=0. Reset mid-RUN aborts the op with no HI/LO write.
- in_valid=0: the FSM ignores aluop/funct; an in-flight op continues.

Decomposition:
- Package exec_pkg holds:
  - aluop codes,
  - funct constants,
  - an internal op enum: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MDU, OP_ILL,
  - MDU state enum.
- One sub-module, mdu_iter, contains the FSM, counter, HI/LO and the sign-fix logic. The top level holds the decode, the datapath mux and the stall logic.

Test Plan:
- Single-cycle ops, WIDTH=32:
  - aluop=10 sub, a=5, b=7 -> result=0xFFFFFFFE, zero=0.
  - slt, a=0xFFFFFFFF, b=1 -> result=1.
  - sltu with the same operands -> result=0.
  - sra, b=0x80000000, shamt=4 -> result=0xF8000000.
- multu, a=0xFFFFFFFF, b=2 -> mdu_busy high for 33 cycles; then mflo=0xFFFFFFFE and mfhi=1.
- Back-to-back dependency:
  - issue mult, then mfhi next cycle -> stall held for 33 cycles; mfhi completes in cycle t+34.
  - an unrelated add issued during RUN -> no stall.
- Signed division:
  - div a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
  - divu a=9, b=0 -> LO=0xFFFFFFFF, HI=9.
- Reset:
  - rst pulsed during RUN (cycle t+10) -> mdu_busy=0 next cycle; HI/LO=0; a new mult is accepted immediately.
  - funct=111111 with aluop=10 -> illegal=1, result=0, HI/LO unchanged.

Source files
------------

// File: rtl/exec_alu_mdu_pkg.sv
// Shared decode constants and enums for the execute-stage ALU and its multiply/divide unit.
package exec_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MDU, OP_ILL
  } alu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE, MDU_RUN, MDU_DONE
  } mdu_state_e;

endpackage

// File: rtl/exec_alu_mdu_if.sv
// Execute-stage instruction/result bundle between the pipeline and the ALU.
interface exec_alu_mdu_if #(parameter int unsigned WIDTH = 32);
  logic             in_valid;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             stall;
  logic             mdu_busy;
  logic             illegal;

  modport master (
    output in_valid, aluop, funct, a, b, shamt,
    input  result, zero, stall, mdu_busy, illegal
  );

  modport slave (
    input  in_valid, aluop, funct, a, b, shamt,
    output result, zero, stall, mdu_busy, illegal
  );
endinterface

// File: rtl/exec_alu_mdu_mdu.sv
// Iterative multiply/divide unit: WIDTH shift-add or restoring-subtract steps, then sign fix into HI/LO.
module mdu_iter
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, q_q, m_q, a_keep_q;
  logic             div_q, neg_a_q, neg_b_q, dz_q;

  logic [WIDTH-1:0] acc_step, q_step, hi_fix, lo_fix;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  logic             sgn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == MDU_RUN) ? cnt_q + CNT_W'(1) : '0;
      busy    <= (state_d != MDU_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (start) state_d = MDU_RUN;
      MDU_RUN:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MDU_DONE;
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  // One iteration: acc:q acts as the product/remainder:quotient shift pair.
  always_comb begin
    acc_step = acc_q;
    q_step   = q_q;
    sum      = {1'b0, acc_q} + {1'b0, (q_q[0] ? m_q : '0)};
    shifted  = {acc_q, q_q[WIDTH-1]};
    diff     = shifted - {1'b0, m_q};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        acc_step = diff[WIDTH-1:0];
        q_step   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = shifted[WIDTH-1:0];
        q_step   = {q_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = sum[WIDTH:1];
      q_step   = {sum[0], q_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = (neg_a_q ^ neg_b_q) ? -{acc_q, q_q} : {acc_q, q_q};
    hi_fix = prod[2*WIDTH-1:WIDTH];
    lo_fix = prod[WIDTH-1:0];
    if (div_q) begin
      if (dz_q) begin
        lo_fix = '1;
        hi_fix = a_keep_q;
      end else begin
        lo_fix = (neg_a_q ^ neg_b_q) ? -q_q : q_q;
        hi_fix = neg_a_q ? -acc_q : acc_q;
      end
    end
  end

  assign sgn = ~is_unsigned;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      a_keep_q <= '0;
      div_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        MDU_IDLE: if (start) begin
          neg_a_q  <= sgn & a[WIDTH-1];
          neg_b_q  <= sgn & b[WIDTH-1];
          q_q      <= (sgn & a[WIDTH-1]) ? -a : a;
          m_q      <= (sgn & b[WIDTH-1]) ? -b : b;
          acc_q    <= '0;
          a_keep_q <= a;
          div_q    <= is_div;
          dz_q     <= (b == '0);
        end
        MDU_RUN: begin
          acc_q <= acc_step;
          q_q   <= q_step;
        end
        MDU_DONE: begin
          hi <= hi_fix;
          lo <= lo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/exec_alu_mdu.sv
// Execute-stage ALU: aluop/funct decode, single-cycle datapath, MDU dispatch and hazard stall.
module exec_alu_mdu
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic      clk,
  input  logic      rst,
  exec_alu_mdu_if.slave bus
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  alu_op_e          op;
  logic [SH_W-1:0]  sh;
  logic [WIDTH-1:0] hi, lo;
  logic             start;

  always_comb begin
    op = OP_ILL;
    case (bus.aluop)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_OR:  op = OP_OR;
      default: begin
        case (bus.funct)
          FN_ADD:  op = OP_ADD;
          FN_SUB:  op = OP_SUB;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_XOR:  op = OP_XOR;
          FN_NOR:  op = OP_NOR;
          FN_SLT:  op = OP_SLT;
          FN_SLTU: op = OP_SLTU;
          FN_SLL:  op = OP_SLL;
          FN_SRL:  op = OP_SRL;
          FN_SRA:  op = OP_SRA;
          FN_MFHI: op = OP_MFHI;
          FN_MFLO: op = OP_MFLO;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: op = OP_MDU;
          default: op = OP_ILL;
        endcase
      end
    endcase
  end

  assign sh = bus.shamt[SH_W-1:0];

  always_comb begin
    bus.result = '0;
    case (op)
      OP_ADD:  bus.result = bus.a + bus.b;
      OP_SUB:  bus.result = bus.a - bus.b;
      OP_AND:  bus.result = bus.a & bus.b;
      OP_OR:   bus.result = bus.a | bus.b;
      OP_XOR:  bus.result = bus.a ^ bus.b;
      OP_NOR:  bus.result = ~(bus.a | bus.b);
      OP_SLT:  bus.result = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_SLTU: bus.result = WIDTH'(bus.a < bus.b);
      OP_SLL:  bus.result = bus.b << sh;
      OP_SRL:  bus.result = bus.b >> sh;
      OP_SRA:  bus.result = WIDTH'($signed(bus.b) >>> sh);
      OP_MFHI: bus.result = hi;
      OP_MFLO: bus.result = lo;
      default: bus.result = '0;
    endcase
  end

  assign bus.zero    = (bus.result == '0);
  assign bus.illegal = bus.in_valid & (op == OP_ILL);
  // HI/LO readers and a second MDU op wait out the whole in-flight operation, DONE included.
  assign bus.stall   = bus.in_valid & bus.mdu_busy &
                       ((op == OP_MDU) | (op == OP_MFHI) | (op == OP_MFLO));
  assign start       = bus.in_valid & (op == OP_MDU) & ~bus.stall;

  mdu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mdu (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_div      (bus.funct[1]),
    .is_unsigned (bus.funct[0]),
    .a           (bus.a),
    .b           (bus.b),
    .busy        (bus.mdu_busy),
    .hi          (hi),
    .lo          (lo)
  );

endmodule

// File: tb/tb_exec_alu_mdu.sv
// Directed-vector bench for exec_alu_mdu at WIDTH=32.
module tb_exec_alu_mdu;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;

  exec_alu_mdu_if #(.WIDTH(32)) bus ();

  exec_alu_mdu #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one EX cycle from the falling edge, then settle before sampling.
  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] aa, input logic [31:0] bb, input logic [4:0] sh);
    @(negedge clk);
    bus.in_valid = v;
    bus.aluop    = op;
    bus.funct    = fn;
    bus.a        = aa;
    bus.b        = bb;
    bus.shamt    = sh;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, ALUOP_ADD, 6'd0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 60; k++) begin
      idle();
      if (!bus.mdu_busy) break;
    end
    if (k == 60) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(1'b1, ALUOP_RTYPE, FN_MFHI, 32'd0, 32'd0, 5'd0);
    check({tag, "_hi"}, bus.result, exp_hi);
    drive(1'b1, ALUOP_RTYPE, FN_MFLO, 32'd0, 32'd0, 5'd0);
    check({tag, "_lo"}, bus.result, exp_lo);
  endtask

  task automatic run_mdu(input string tag, input logic [5:0] fn, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(1'b1, ALUOP_RTYPE, fn, aa, bb, 5'd0);
    check({tag, "_issue_stall"}, 32'(bus.stall), 32'd0);
    wait_idle(tag);
    read_hilo(tag, exp_hi, exp_lo);
  endtask

  initial begin
    int busy_cnt;
    int stall_cnt;
    logic busy_last, busy_after;

    bus.in_valid = 1'b0;
    bus.aluop    = 2'b00;
    bus.funct    = 6'd0;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    bus.shamt    = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    idle();
    check("rst_busy", 32'(bus.mdu_busy), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    read_hilo("rst", 32'd0, 32'd0);

    drive(1'b1, ALUOP_RTYPE, FN_SUB, 32'd5, 32'd7, 5'd0);
    check("sub", bus.result, 32'hFFFF_FFFE);
    check("sub_zero", 32'(bus.zero), 32'd0);
    drive(1'b1, ALUOP_ADD, 6'd0, 32'd5, 32'hFFFF_FFFB, 5'd0);
    check("add_wrap_zero", 32'(bus.zero), 32'd1);
    drive(1'b1, ALUOP_OR, 6'd0, 32'h0000_F0F0, 32'h0000_0F0F, 5'd0);
    check("ori", bus.result, 32'h0000_FFFF);
    drive(1'b1, ALUOP_RTYPE, FN_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
    check("slt", bus.result, 32'd1);
    drive(1'b1, ALUOP_RTYPE, FN_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0);
    check("sltu", bus.result, 32'd0);
    drive(1'b1, ALUOP_RTYPE, FN_SRA, 32'd0, 32'h8000_0000, 5'd4);
    check("sra", bus.result, 32'hF800_0000);
    drive(1'b1, ALUOP_RTYPE, FN_SRL, 32'd0, 32'h8000_0000, 5'd4);
    check("srl", bus.result, 32'h0800_0000);
    drive(1'b1, ALUOP_RTYPE, FN_NOR, 32'h0F0F_0000, 32'h0000_00FF, 5'd0);
    check("nor", bus.result, 32'hF0F0_FF00);

    // multu: count busy cycles after the accept cycle
    drive(1'b1, ALUOP_RTYPE, FN_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0);
    check("multu_issue_stall", 32'(bus.stall), 32'd0);
    busy_cnt = 0; busy_last = 1'b0; busy_after = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      idle();
      if (bus.mdu_busy) busy_cnt++;
      if (k == 33) busy_last = bus.mdu_busy;
      if (k == 34) busy_after = bus.mdu_busy;
    end
    check("multu_busy_cycles", 32'(busy_cnt), 32'd33);
    check("multu_busy_t33", 32'(busy_last), 32'd1);
    check("multu_busy_t34", 32'(busy_after), 32'd0);
    read_hilo("multu", 32'd1, 32'hFFFF_FFFE);

    // mult then dependent mfhi in the next cycle
    drive(1'b1, ALUOP_RTYPE, FN_MULT, 32'd3, 32'hFFFF_FFFE, 5'd0);
    stall_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      drive(1'b1, ALUOP_RTYPE, FN_MFHI, 32'd0, 32'd0, 5'd0);
      if (!bus.stall) break;
      stall_cnt++;
    end
    check("mfhi_stall_cycles", 32'(stall_cnt), 32'd33);
    check("mult_hi", bus.result, 32'hFFFF_FFFF);
    drive(1'b1, ALUOP_RTYPE, FN_MFLO, 32'd0, 32'd0, 5'd0);
    check("mult_lo", bus.result, 32'hFFFF_FFFA);

    // unrelated add while the MDU runs, then mflo waits out the remainder
    drive(1'b1, ALUOP_RTYPE, FN_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 5'd0);
    drive(1'b1, ALUOP_ADD, 6'd0, 32'd1, 32'd2, 5'd0);
    check("run_add_stall", 32'(bus.stall), 32'd0);
    check("run_add_busy", 32'(bus.mdu_busy), 32'd1);
    check("run_add", bus.result, 32'd3);
    stall_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      drive(1'b1, ALUOP_RTYPE, FN_MFLO, 32'd0, 32'd0, 5'd0);
      if (!bus.stall) break;
      stall_cnt++;
    end
    check("mflo_stall_cycles", 32'(stall_cnt), 32'd32);
    check("mult_negneg_lo", bus.result, 32'd42);

    run_mdu("div_m7_2", FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_mdu("div_min_m1", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_mdu("divu_by0", FN_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    run_mdu("divu_100_7", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_mdu("div_by0", FN_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // reset in cycle t+10 of a running mult
    drive(1'b1, ALUOP_RTYPE, FN_MULT, 32'd5, 32'd7, 5'd0);
    repeat (9) idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.mdu_busy), 32'd0);
    read_hilo("rst_mid", 32'd0, 32'd0);
    drive(1'b1, ALUOP_RTYPE, FN_MULT, 32'd5, 32'd7, 5'd0);
    check("post_rst_issue_stall", 32'(bus.stall), 32'd0);
    idle();
    check("post_rst_busy", 32'(bus.mdu_busy), 32'd1);
    wait_idle("post_rst");
    read_hilo("post_rst", 32'd0, 32'd35);

    drive(1'b1, ALUOP_RTYPE, 6'b111111, 32'd1, 32'd2, 5'd0);
    check("ill_flag", 32'(bus.illegal), 32'd1);
    check("ill_result", bus.result, 32'd0);
    drive(1'b0, ALUOP_RTYPE, 6'b111111, 32'd1, 32'd2, 5'd0);
    check("ill_invalid", 32'(bus.illegal), 32'd0);
    check("ill_busy", 32'(bus.mdu_busy), 32'd0);
    read_hilo("ill", 32'd0, 32'd35);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
